// File: rtl/apb2ahb_bridge_if.sv
// APB-slave / AHB-Lite-master bundle for apb2ahb_bridge.
// 'slave' is the bridge view: APB target on one side, AHB initiator on the other.
// 'master' is the environment view: APB initiator plus AHB slave.
interface apb2ahb_bridge_if #(
  parameter int ADDRWIDTH = 32
);
  // APB side
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [31:0]          PWDATA;
  logic [3:0]           PSTRB;
  logic [2:0]           PPROT;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;
  // AHB-Lite side
  logic [ADDRWIDTH-1:0] HADDR;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic                 HWRITE;
  logic [3:0]           HPROT;
  logic [31:0]          HWDATA;
  logic [31:0]          HRDATA;
  logic                 HREADY;
  logic                 HRESP;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR,
    output HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR,
    input  HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/apb2ahb_bridge.sv
// APB slave to AHB-Lite master bridge. One single transfer in flight at a
// time; APB setup is accepted only in IDLE, the AHB transfer runs through an
// address and a data phase, and DONE returns a one-cycle PREADY pulse.
module apb2ahb_bridge #(
  parameter int ADDRWIDTH      = 32,
  parameter bit REGISTER_RDATA = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  apb2ahb_bridge_if.slave   bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic        wr_q;      // direction of the access in flight (also for rejected writes)
  logic [31:0] wdata_q;   // write data parked until the AHB data phase
  logic [31:0] rdata_q;   // read data held for the DONE cycle

  // Strobe decode for the live setup phase
  logic       strb_ok;
  logic [2:0] size_d;
  logic [1:0] lane_d;

  // Legal write strobes are naturally aligned byte/half/word lanes; reads are always word
  always_comb begin
    strb_ok = 1'b0;
    size_d  = 3'b010;
    lane_d  = 2'b00;
    if (!bus.PWRITE) begin
      strb_ok = 1'b1;
    end else begin
      unique case (bus.PSTRB)
        4'b0001: begin strb_ok = 1'b1; size_d = 3'b000; lane_d = 2'b00; end
        4'b0010: begin strb_ok = 1'b1; size_d = 3'b000; lane_d = 2'b01; end
        4'b0100: begin strb_ok = 1'b1; size_d = 3'b000; lane_d = 2'b10; end
        4'b1000: begin strb_ok = 1'b1; size_d = 3'b000; lane_d = 2'b11; end
        4'b0011: begin strb_ok = 1'b1; size_d = 3'b001; lane_d = 2'b00; end
        4'b1100: begin strb_ok = 1'b1; size_d = 3'b001; lane_d = 2'b10; end
        4'b1111: begin strb_ok = 1'b1; size_d = 3'b010; lane_d = 2'b00; end
        default: begin strb_ok = 1'b0; end
      endcase
    end
  end

  // Transfer FSM; every bus output except PRDATA is a register of this block
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      bus.HADDR   <= '0;
      bus.HTRANS  <= HTRANS_IDLE;
      bus.HSIZE   <= '0;
      bus.HWRITE  <= 1'b0;
      bus.HPROT   <= '0;
      bus.HWDATA  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            wr_q    <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            if (!strb_ok) begin
              // Rejected write: answer with an error without touching AHB
              state       <= S_DONE;
              bus.PREADY  <= 1'b1;
              bus.PSLVERR <= 1'b1;
            end else begin
              state      <= S_ADDR;
              bus.HTRANS <= HTRANS_NONSEQ;
              bus.HADDR  <= {bus.PADDR[ADDRWIDTH-1:2], lane_d};
              bus.HSIZE  <= size_d;
              bus.HWRITE <= bus.PWRITE;
              bus.HPROT  <= {2'b00, bus.PPROT[0], ~bus.PPROT[2]};
            end
          end
        end
        S_ADDR: begin
          // Address phase outputs simply stay put while HREADY is low
          if (bus.HREADY) begin
            state      <= S_DATA;
            bus.HTRANS <= HTRANS_IDLE;
            bus.HWDATA <= wdata_q;
          end
        end
        S_DATA: begin
          // First cycle of a two-cycle ERROR has HREADY low and is waited out here
          if (bus.HREADY) begin
            state       <= S_DONE;
            bus.PREADY  <= 1'b1;
            bus.PSLVERR <= bus.HRESP;
            rdata_q     <= wr_q ? 32'h0 : bus.HRDATA;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          bus.PREADY  <= 1'b0;
          bus.PSLVERR <= 1'b0;
          rdata_q     <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data: registered copy, or HRDATA passed straight through during DONE
  generate
    if (REGISTER_RDATA) begin : g_rdata_reg
      assign bus.PRDATA = rdata_q;
    end else begin : g_rdata_comb
      logic unused_rdata;
      assign bus.PRDATA   = (state == S_DONE && !wr_q) ? bus.HRDATA : 32'h0;
      assign unused_rdata = ^rdata_q;
    end
  endgenerate

  // Address byte offset comes from the strobes; PPROT[1] has no AHB-Lite counterpart
  logic unused_in;
  assign unused_in = ^{bus.PADDR[1:0], bus.PPROT[1]};

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Randomized scoreboard bench for apb2ahb_bridge: APB driver, AHB slave
// with a byte-lane memory, and an APB response monitor.
module tb_apb2ahb_bridge;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  apb2ahb_bridge_if #(.ADDRWIDTH(32)) bus ();

  apb2ahb_bridge #(.ADDRWIDTH(32), .REGISTER_RDATA(1'b1)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } apb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [3:0]  prot;
    logic [31:0] wdata;
    int          aw;
    int          dw;
  } ahb_exp_t;

  apb_exp_t    apb_q[$];
  ahb_exp_t    ahb_q[$];
  logic [31:0] mem_ref[int unsigned];
  logic [31:0] mem_ahb[int unsigned];

  localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference model: a strobe is legal if it covers 1, 2 or 4 contiguous,
  // naturally aligned bytes
  function automatic bit strobe_legal(input logic [3:0] s, output int n, output int low);
    logic [3:0] mask;
    n   = $countones(s);
    low = 0;
    for (int i = 3; i >= 0; i--) if (s[i]) low = i;
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    mask = 4'(((1 << n) - 1) << low);
    return (low % n == 0) && (s == mask);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    return mem_ref.exists(addr >> 2) ? mem_ref[addr >> 2] : 32'h0;
  endfunction

  // Predict both the AHB transfer and the APB response for one access
  task automatic plan(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int aw, input int dw);
    int n, low;
    bit legal, err;
    ahb_exp_t a;
    apb_exp_t e;
    logic [31:0] w;
    legal = 1'b1;
    n = 4; low = 0;
    if (wr) legal = strobe_legal(strb, n, low);
    err = (addr[15:12] == 4'hF);
    if (!legal) begin
      e.rdata = 32'h0; e.err = 1'b1;
    end else begin
      a.addr  = {addr[31:2], 2'(low)};
      a.size  = 3'($clog2(n));
      a.wr    = wr;
      a.prot  = {2'b00, prot[0], ~prot[2]};
      a.wdata = wdata;
      a.aw    = aw;
      a.dw    = dw;
      ahb_q.push_back(a);
      if (wr) begin
        e.rdata = 32'h0; e.err = err;
        if (!err) begin
          w = ref_word(addr);
          for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
          mem_ref[addr >> 2] = w;
        end
      end else begin
        e.rdata = err ? ERR_DATA : ref_word(addr);
        e.err   = err;
      end
    end
    apb_q.push_back(e);
  endtask

  task automatic apb_drive(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, output int lat);
    @(posedge HCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr;
    bus.PWDATA = wdata; bus.PSTRB = strb; bus.PPROT = prot;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    lat = 1;
    while (!bus.PREADY && lat < 100) begin
      @(posedge HCLK); #1;
      lat++;
    end
    if (!bus.PREADY) flag("apb_timeout");
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int aw, input int dw,
                      output int lat);
    plan(wr, addr, wdata, strb, prot, aw, dw);
    apb_drive(wr, addr, wdata, strb, prot, lat);
  endtask

  // AHB slave: wait states per planned transfer, ERROR for 0xFxxx, byte-lane memory
  initial begin
    ahb_exp_t a;
    logic [39:0] cap;
    logic [31:0] w;
    bit err;
    int off, nb;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      if (HRESETn && bus.HTRANS == 2'b10) begin
        if (ahb_q.size() == 0) begin
          flag("unexpected_nonseq");
          continue;
        end
        a = ahb_q.pop_front();
        cap = {bus.HADDR, bus.HSIZE, bus.HWRITE, bus.HPROT};
        check("addr_phase", cap, {a.addr, a.size, a.wr, a.prot});
        for (int i = 0; i < a.aw; i++) begin
          bus.HREADY = 1'b0;
          @(negedge HCLK);
          check("addr_hold", {bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE, bus.HPROT}, {2'b10, cap});
        end
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        check("data_htrans_idle", bus.HTRANS, 2'b00);
        err = (cap[39:8] >> 12) % 16 == 15;
        for (int i = 0; i < a.dw; i++) begin
          bus.HREADY = 1'b0; bus.HRESP = 1'b0;
          @(negedge HCLK);
          if (a.wr) check("hwdata_hold", bus.HWDATA, a.wdata);
        end
        if (err) begin
          bus.HREADY = 1'b0; bus.HRESP = 1'b1;
          @(negedge HCLK);
        end
        bus.HREADY = 1'b1; bus.HRESP = err;
        if (a.wr) begin
          check("hwdata", bus.HWDATA, a.wdata);
          if (!err) begin
            w   = mem_ahb.exists(cap[39:10]) ? mem_ahb[cap[39:10]] : 32'h0;
            off = int'(cap[9:8]);
            nb  = 1 << int'(cap[7:5]);
            for (int b = off; b < off + nb && b < 4; b++) w[8*b +: 8] = bus.HWDATA[8*b +: 8];
            mem_ahb[cap[39:10]] = w;
          end
        end else begin
          bus.HRDATA = err ? ERR_DATA : (mem_ahb.exists(cap[39:10]) ? mem_ahb[cap[39:10]] : 32'h0);
        end
        @(negedge HCLK);
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end
    end
  end

  // APB monitor: pops the oldest expected response whenever PREADY is seen
  initial begin
    apb_exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        if (bus.PREADY) begin
          if (apb_q.size() == 0) flag("unexpected_pready");
          else begin
            e = apb_q.pop_front();
            check("apb_resp", {bus.PRDATA, bus.PSLVERR}, {e.rdata, e.err});
          end
        end else begin
          check("apb_idle_zero", {bus.PRDATA, bus.PSLVERR}, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int lat;
    logic [31:0] addr, wdata;
    logic [3:0] strb;
    logic [3:0] legal_strb[7];
    logic [31:0] bases[4];
    logic wr;
    legal_strb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    bases = '{32'h1000, 32'h2000, 32'h3000, 32'hF000};
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0;
    bus.PWDATA = 0; bus.PSTRB = 0; bus.PPROT = 0;

    #12;
    check("reset_outputs",
          {bus.PRDATA, bus.PREADY, bus.PSLVERR, bus.HADDR, bus.HTRANS, bus.HSIZE,
           bus.HWRITE, bus.HPROT, bus.HWDATA}, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Word write, zero wait states: PREADY in T3
    xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 3'b000, 0, 0, lat);
    check("lat_word_write", lat, 3);
    // Byte and half writes into the same word
    xfer(1'b1, 32'h0000_2000, 32'h00AB_0000, 4'b0100, 3'b101, 0, 0, lat);
    check("lat_byte_write", lat, 3);
    xfer(1'b1, 32'h0000_2000, 32'hCDEF_0000, 4'b1100, 3'b001, 0, 0, lat);
    xfer(1'b0, 32'h0000_2000, 32'h0, 4'b0000, 3'b000, 0, 0, lat);
    // Read with 2 address and 3 data wait states: PREADY in T8
    xfer(1'b1, 32'h0000_3000, 32'h1234_5678, 4'b1111, 3'b000, 0, 0, lat);
    xfer(1'b0, 32'h0000_3000, 32'h0, 4'b1010, 3'b100, 2, 3, lat);
    check("lat_read_waits", lat, 8);
    // Two-cycle AHB ERROR adds one cycle
    xfer(1'b1, 32'h0000_F010, 32'h5555_AAAA, 4'b1111, 3'b000, 0, 0, lat);
    check("lat_ahb_error", lat, 4);
    // Illegal strobe: no AHB transfer, error in T1
    xfer(1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 4'b0101, 3'b000, 0, 0, lat);
    check("lat_illegal_strobe", lat, 1);
    xfer(1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 4'b0000, 3'b000, 0, 0, lat);
    check("lat_zero_strobe", lat, 1);

    // Random mix
    for (int t = 0; t < 120; t++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      wdata = $urandom;
      strb  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_strb[$urandom_range(0, 6)];
      xfer(wr, addr, wdata, strb, 3'($urandom_range(0, 7)),
           $urandom_range(0, 2), $urandom_range(0, 2), lat);
    end

    // Reset during the data phase of a read
    plan(1'b0, 32'h0000_1004, 32'h0, 4'b0000, 3'b000, 0, 6);
    void'(apb_q.pop_back());
    @(posedge HCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h1004;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge HCLK); #1;
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    check("reset_mid_data",
          {bus.PRDATA, bus.PREADY, bus.PSLVERR, bus.HADDR, bus.HTRANS, bus.HSIZE,
           bus.HWRITE, bus.HPROT, bus.HWDATA}, 0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (12) @(negedge HCLK);
    xfer(1'b0, 32'h0000_1004, 32'h0, 4'b0000, 3'b000, 0, 0, lat);
    check("lat_read_after_reset", lat, 3);

    repeat (5) @(negedge HCLK);
    if (apb_q.size() != 0) flag("apb_responses_missing");
    if (ahb_q.size() != 0) flag("ahb_transfers_missing");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
